// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC RX frame sequencer: XGMII control
// characters, frame buffer depth, sequencer states and the per-cycle lane decode.
package mac_pkg;

  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  localparam int unsigned MAC_MAX_WORDS = 256;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDeliver
  } rx_seq_state_e;

  typedef struct packed {
    logic       is_start;
    logic       is_term;
    logic [2:0] term_lane;
    logic       bad_ctrl;
  } lane_decode_t;

endpackage

// File: rtl/mac_rx_lane_decoder.sv
// Combinational decode of one RX word: START in lane 0, lowest TERM lane, and
// any non-TERM control character sitting below the TERM lane.
module mac_rx_lane_decoder
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter logic [7:0]  START_CODE = XGMII_START,
  parameter logic [7:0]  TERM_CODE  = XGMII_TERM
) (
  input  logic [DATA_WIDTH-1:0] i_rxd,
  input  logic [CTRL_WIDTH-1:0] i_rxc,
  output lane_decode_t          o_dec
);

  logic w_found;

  always_comb begin
    o_dec          = '0;
    w_found        = 1'b0;
    o_dec.is_start = i_rxc[0] && (i_rxd[7:0] == START_CODE);
    // Lanes above the first TERM are end-of-frame fill and are not inspected.
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      if (!w_found && i_rxc[k]) begin
        if (i_rxd[8*k +: 8] == TERM_CODE) begin
          o_dec.is_term   = 1'b1;
          o_dec.term_lane = 3'(k);
          w_found         = 1'b1;
        end else begin
          o_dec.bad_ctrl = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_rx_frame_sequencer.sv
// Captures RX frames (START..TERM) into a word buffer and hands them to the frame
// checker with valid/ack. Define MAC_RX_SEQ_STATS_EN to add saturating frame counters.
module mac_rx_frame_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = MAC_MAX_WORDS,
  parameter logic [7:0]  START_CODE = XGMII_START,
  parameter logic [7:0]  TERM_CODE  = XGMII_TERM,
  parameter logic [7:0]  IDLE_CODE  = XGMII_IDLE
) (
  input  logic                            clk,
  input  logic                            i_rst_n,
  input  logic [DATA_WIDTH-1:0]           i_rxd,
  input  logic [CTRL_WIDTH-1:0]           i_rxc,
  input  logic                            i_frame_ack,
  output logic [DATA_WIDTH*MAX_WORDS-1:0] o_rx_data,
  output logic                            o_frame_valid,
  output logic [8:0]                      o_word_count,
  output logic [15:0]                     o_frame_bytes,
  output logic                            o_ctrl_error,
  output logic                            o_drop,
`ifdef MAC_RX_SEQ_STATS_EN
  output logic [31:0]                     o_frames_ok,
  output logic [31:0]                     o_frames_dropped,
  output logic [31:0]                     o_frames_overflow,
`endif
  output logic                            o_overflow
);

  localparam int unsigned AW    = $clog2(MAX_WORDS);
  localparam logic [8:0]  W_MAX = 9'(MAX_WORDS);

  if (IDLE_CODE == START_CODE || IDLE_CODE == TERM_CODE || START_CODE == TERM_CODE)
  begin : g_code_check
    $error("mac_rx_frame_sequencer: START/TERM/IDLE codes must be distinct");
  end

  lane_decode_t          w_dec;
  rx_seq_state_e         r_state;
  logic [8:0]            r_count;
  logic                  r_skip;
  logic                  r_ctrl_err;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_idx;
  logic [DATA_WIDTH-1:0] r_buf [MAX_WORDS];

  mac_rx_lane_decoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .START_CODE (START_CODE),
    .TERM_CODE  (TERM_CODE)
  ) u_lane_decoder (
    .i_rxd (i_rxd),
    .i_rxc (i_rxc),
    .o_dec (w_dec)
  );

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = '0;
    case (r_state)
      StIdle:    w_wr_en = !r_skip && w_dec.is_start;
      StCapture: begin
        if (w_dec.is_start) begin
          w_wr_en = 1'b1;
        end else if (r_count != W_MAX) begin
          w_wr_en  = 1'b1;
          w_wr_idx = r_count[AW-1:0];
        end
      end
      default: ;
    endcase
  end

  // Buffer contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_idx] <= i_rxd;
  end

  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_rx_data
    assign o_rx_data[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_skip        <= 1'b0;
      r_ctrl_err    <= 1'b0;
      o_frame_valid <= 1'b0;
      o_word_count  <= '0;
      o_frame_bytes <= '0;
      o_ctrl_error  <= 1'b0;
      o_drop        <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_drop     <= 1'b0;
      o_overflow <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_skip) begin
            if (w_dec.is_term) r_skip <= 1'b0;
          end else if (w_dec.is_start) begin
            r_count    <= 9'd1;
            r_ctrl_err <= 1'b0;
            r_state    <= StCapture;
          end
        end
        StCapture: begin
          if (w_dec.is_start) begin
            o_drop     <= 1'b1;
            r_count    <= 9'd1;
            r_ctrl_err <= 1'b0;
          end else if (r_count == W_MAX) begin
            o_drop     <= 1'b1;
            o_overflow <= 1'b1;
            r_skip     <= !w_dec.is_term;
            r_state    <= StIdle;
          end else begin
            r_count <= r_count + 9'd1;
            if (w_dec.is_term) begin
              o_frame_bytes <= {4'b0, r_count, 3'b0} + {13'b0, w_dec.term_lane};
              o_word_count  <= r_count + 9'd1;
              o_ctrl_error  <= r_ctrl_err | w_dec.bad_ctrl;
              o_frame_valid <= 1'b1;
              r_state       <= StDeliver;
            end else begin
              r_ctrl_err <= r_ctrl_err | w_dec.bad_ctrl;
            end
          end
        end
        StDeliver: begin
          // A frame starting while the checker holds the buffer is dropped whole.
          if (w_dec.is_start && !r_skip) begin
            o_drop <= 1'b1;
            r_skip <= 1'b1;
          end else if (r_skip && w_dec.is_term) begin
            r_skip <= 1'b0;
          end
          if (i_frame_ack) begin
            o_frame_valid <= 1'b0;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef MAC_RX_SEQ_STATS_EN
  logic        w_deliver;
  logic [31:0] r_frames_ok;
  logic [31:0] r_frames_dropped;
  logic [31:0] r_frames_overflow;

  assign w_deliver = (r_state == StCapture) && !w_dec.is_start && (r_count != W_MAX) &&
                     w_dec.is_term;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frames_ok       <= '0;
      r_frames_dropped  <= '0;
      r_frames_overflow <= '0;
    end else begin
      if (w_deliver && r_frames_ok != '1)         r_frames_ok       <= r_frames_ok + 32'd1;
      if (o_drop && r_frames_dropped != '1)       r_frames_dropped  <= r_frames_dropped + 32'd1;
      if (o_overflow && r_frames_overflow != '1)  r_frames_overflow <= r_frames_overflow + 32'd1;
    end
  end

  assign o_frames_ok       = r_frames_ok;
  assign o_frames_dropped  = r_frames_dropped;
  assign o_frames_overflow = r_frames_overflow;
`endif

endmodule

// File: tb/tb_mac_rx_frame_sequencer.sv
// Directed bench for mac_rx_frame_sequencer: expected frame descriptors are queued as
// frames are driven and popped/compared when the sequencer presents the frame.
module tb_mac_rx_frame_sequencer;
  import mac_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned MW = 256;
  localparam logic [63:0] START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [DW-1:0]    i_rxd;
  logic [CW-1:0]    i_rxc;
  logic             i_frame_ack;
  logic [DW*MW-1:0] o_rx_data;
  logic             o_frame_valid;
  logic [8:0]       o_word_count;
  logic [15:0]      o_frame_bytes;
  logic             o_ctrl_error;
  logic             o_drop;
  logic             o_overflow;
`ifdef MAC_RX_SEQ_STATS_EN
  logic [31:0]      o_frames_ok;
  logic [31:0]      o_frames_dropped;
  logic [31:0]      o_frames_overflow;
`endif

  typedef struct {
    int unsigned wc;
    int unsigned fb;
    bit          ce;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] words[$];
  int n_tests = 0, n_fail = 0;
  int drops_seen = 0, ovf_seen = 0, drops_exp = 0, ovf_exp = 0, ok_exp = 0;

  mac_rx_frame_sequencer dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_rxd         (i_rxd),
    .i_rxc         (i_rxc),
    .i_frame_ack   (i_frame_ack),
    .o_rx_data     (o_rx_data),
    .o_frame_valid (o_frame_valid),
    .o_word_count  (o_word_count),
    .o_frame_bytes (o_frame_bytes),
    .o_ctrl_error  (o_ctrl_error),
    .o_drop        (o_drop),
`ifdef MAC_RX_SEQ_STATS_EN
    .o_frames_ok       (o_frames_ok),
    .o_frames_dropped  (o_frames_dropped),
    .o_frames_overflow (o_frames_overflow),
`endif
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_drop === 1'b1) drops_seen++;
    if (o_overflow === 1'b1) ovf_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [63:0] d, input logic [7:0] c);
    i_rxd = d;
    i_rxc = c;
    @(negedge clk);
  endtask

  // bad_word > 0 places control 8'hFE in lane 3 of that payload word.
  task automatic send_frame(input int n_pay, input int tlane, input int bad_word,
                            input bit track);
    logic [63:0] d;
    logic [7:0]  c;
    exp_t        e;
    if (track) words.delete();
    if (track) words.push_back(START_WORD);
    tick(START_WORD, 8'h01);
    for (int j = 1; j <= n_pay; j++) begin
      d = {$urandom, $urandom};
      c = 8'h00;
      if (j == bad_word) begin
        d[31:24] = 8'hFE;
        c        = 8'h08;
      end
      if (track) words.push_back(d);
      tick(d, c);
    end
    d = {$urandom, $urandom};
    c = 8'h00;
    for (int k = tlane; k < 8; k++) begin
      d[8*k +: 8] = (k == tlane) ? XGMII_TERM : XGMII_IDLE;
      c[k]        = 1'b1;
    end
    if (track) words.push_back(d);
    tick(d, c);
    i_rxd = IDLE_WORD;
    i_rxc = 8'hFF;
    if (track) begin
      e.wc = n_pay + 2;
      e.fb = (n_pay + 1) * 8 + tlane;
      e.ce = (bad_word > 0);
      sb.push_back(e);
    end
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    int   waited = 0;
    bit   ok = 1'b1;
    while (o_frame_valid !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, o_frame_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_word_count"}, o_word_count, e.wc);
      check({tag, "_frame_bytes"}, o_frame_bytes, e.fb);
      check({tag, "_ctrl_error"}, o_ctrl_error, e.ce);
      for (int i = 0; i < words.size(); i++)
        if (o_rx_data[i*64 +: 64] !== words[i]) ok = 1'b0;
      check({tag, "_buffer"}, ok, 1);
      ok_exp++;
    end
  endtask

  task automatic ack(input string tag);
    i_frame_ack = 1'b1;
    @(negedge clk);
    i_frame_ack = 1'b0;
    check({tag, "_valid_after_ack"}, o_frame_valid, 0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_rxd       = IDLE_WORD;
    i_rxc       = 8'hFF;
    i_frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", o_frame_valid, 0);
    check("reset_word_count", o_word_count, 0);
    check("reset_frame_bytes", o_frame_bytes, 0);
    check("reset_ctrl_error", o_ctrl_error, 0);
    check("reset_drop", o_drop, 0);
    check("reset_overflow", o_overflow, 0);
    i_rst_n = 1'b1;
    @(negedge clk);

    // Minimum frame, TERM in lane 0; valid must be up one cycle after TERM.
    send_frame(8, 0, 0, 1);
    check("min_latency", o_frame_valid, 1);
    expect_frame("min");
    repeat (3) tick(IDLE_WORD, 8'hFF);
    check("min_hold_valid", o_frame_valid, 1);
    check("min_hold_wc", o_word_count, 10);
    ack("min");

    send_frame(8, 5, 0, 1);
    expect_frame("lane5");
    ack("lane5");

    // Frame arriving while the checker holds the buffer is dropped once.
    send_frame(4, 2, 0, 1);
    send_frame(3, 0, 0, 0);
    drops_exp++;
    check("busy_drop_count", drops_seen, drops_exp);
    expect_frame("busy_held");
    ack("busy_held");
    send_frame(5, 7, 0, 1);
    expect_frame("after_busy");
    ack("after_busy");

    // 257 words without TERM overflow the buffer.
    tick(START_WORD, 8'h01);
    repeat (255) tick({$urandom, $urandom}, 8'h00);
    check("ovf_not_yet", o_overflow, 0);
    tick({$urandom, $urandom}, 8'h00);
    check("ovf_drop_pulse", o_drop, 1);
    check("ovf_pulse", o_overflow, 1);
    drops_exp++;
    ovf_exp++;
    repeat (3) tick({$urandom, $urandom}, 8'h00);
    tick(START_WORD, 8'h01);
    tick({$urandom, $urandom}, 8'h00);
    tick({40'h0707070707, XGMII_TERM, 16'h1234}, 8'hFC);
    tick(IDLE_WORD, 8'hFF);
    tick(IDLE_WORD, 8'hFF);
    check("ovf_skip_no_frame", o_frame_valid, 0);
    check("ovf_skip_no_drop", drops_seen, drops_exp);
    send_frame(3, 1, 0, 1);
    expect_frame("after_ovf");
    ack("after_ovf");

    send_frame(6, 4, 3, 1);
    expect_frame("ctrl_err");
    ack("ctrl_err");
    send_frame(6, 4, 0, 1);
    expect_frame("ctrl_clean");
    ack("ctrl_clean");

    // START in lane 0 mid-frame restarts capture.
    tick(START_WORD, 8'h01);
    repeat (3) tick({$urandom, $urandom}, 8'h00);
    send_frame(2, 3, 0, 1);
    drops_exp++;
    check("restart_drop_count", drops_seen, drops_exp);
    expect_frame("restart");
    ack("restart");

    // Asynchronous reset mid-capture clears outputs at once without a drop pulse.
    tick(START_WORD, 8'h01);
    repeat (2) tick({$urandom, $urandom}, 8'h00);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_frame_valid, 0);
    check("mid_rst_word_count", o_word_count, 0);
    check("mid_rst_frame_bytes", o_frame_bytes, 0);
    check("mid_rst_ctrl_error", o_ctrl_error, 0);
    check("mid_rst_drop", o_drop, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_rxd   = IDLE_WORD;
    i_rxc   = 8'hFF;
    @(negedge clk);
    send_frame(8, 5, 0, 1);
    expect_frame("after_rst");
    ack("after_rst");

    check("total_drops", drops_seen, drops_exp);
    check("total_overflows", ovf_seen, ovf_exp);
`ifdef MAC_RX_SEQ_STATS_EN
    // Counters restarted with the mid-capture reset: only the final frame remains.
    check("stats_ok", o_frames_ok, 1);
    check("stats_dropped", o_frames_dropped, 0);
    check("stats_overflow", o_frames_overflow, 0);
`endif
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
